// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: MDop encodings,
// FSM states and the iteration count.
package mult_div_unit_pkg;

  localparam int MD_ITERS = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_core.sv
// Iteration datapath: one shift-add (multiply) or restoring shift-subtract
// (divide) step of a 2*WIDTH accumulator per enabled cycle.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic               mode_div,
  input  logic [WIDTH-1:0]   init_lo,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    acc_d  = acc_q;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd};
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, init_lo};
    end else if (en) begin
      if (mode_div) begin
        // A trial remainder that stays non-negative yields a 1 quotient bit.
        if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        if (acc_q[0]) sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  assign acc_nxt = acc_d;

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: operand conditioning, 32-cycle iteration
// control, sign correction, HI/LO registers and the MFHI/MFLO stall.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             readHL,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic               div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic               dz_q, dz_d, done_q, done_d;
  logic               core_load, core_en;
  logic [WIDTH-1:0]   core_init;
  logic [2*WIDTH-1:0] acc_nxt, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               is_md, is_div_op, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  md_op_e             op;

  assign op = md_op_e'(MDop);

  always_comb begin
    is_md     = op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    is_div_op = (op == MD_DIV) || (op == MD_DIVU);
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    a_neg     = signed_op & A[WIDTH-1];
    b_neg     = signed_op & B[WIDTH-1];
    abs_a     = a_neg ? -A : A;
    abs_b     = b_neg ? -B : B;
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .en       (core_en),
    .mode_div (div_q),
    .init_lo  (core_init),
    .opnd     (opnd_q),
    .acc_nxt  (acc_nxt)
  );

  // Sign correction applied to the value produced by the final iteration.
  always_comb begin
    prod = qneg_q ? -acc_nxt : acc_nxt;
    quo  = dz_q ? '1 : (qneg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0]);
    rem  = rneg_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    core_init = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_md) begin
            core_load = 1'b1;
            core_init = is_div_op ? abs_a : abs_b;
            opnd_d    = is_div_op ? abs_b : abs_a;
            div_d     = is_div_op;
            qneg_d    = a_neg ^ b_neg;
            rneg_d    = a_neg;
            dz_d      = is_div_op && (B == '0);
            cnt_d     = '0;
            state_d   = ST_RUN;
          end else if (op == MD_MTHI) begin
            hi_d = A;
          end else if (op == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        core_en = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MD_ITERS - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign HI    = hi_q;
  assign LO    = lo_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign stall = busy & readHL;

endmodule
